// File: rtl/dsram_pkg.sv
// Shared definitions for the data SRAM response block: default depth,
// byte-lane mask type and the byte-merge helper used by the array,
// the write buffer and the read-forwarding path.
package dsram_pkg;

    localparam int DEPTH_LOG2_DEF = 14;

    typedef logic [3:0] lane_mask_t;

    // Take byte lane i from new_word where mask[i] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input lane_mask_t  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_array.sv
// 1R1W word array with byte-lane write enables and synchronous read-first
// read. Only the read register is cleared by reset; the storage keeps its
// contents. INIT_ZERO selects zero or X start-up contents in simulation.
module dsram_array
    import dsram_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter bit INIT_ZERO  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [31:0]           rd_data,
    input  lane_mask_t            wr_mask,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [31:0]           wr_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    // Byte-lane write; lanes with a clear mask bit keep their old value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
                mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Registered read; sees the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 32'h0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: 1-cycle read latency, read-first, byte-lane stores.
// Optional macro DATA_SRAM_WBUF_EN adds a one-entry write buffer that holds
// the latest store until the next store to another word or the next cycle
// without a store; reads of the buffered word forward its lanes so rdata is
// the same with or without the buffer.
module data_sram_resp
    import dsram_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter bit INIT_ZERO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        wbuf_busy
);

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  store;
    logic                  unused_addr;
    lane_mask_t            wr_mask;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [31:0]           wr_data;
    logic [31:0]           arr_rdata;

    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign req_idx     = data_sram_addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};
    assign store       = data_sram_en && (data_sram_we != 4'b0000);

    dsram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_ZERO  (INIT_ZERO)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (data_sram_en),
        .rd_idx  (req_idx),
        .rd_data (arr_rdata),
        .wr_mask (wr_mask),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

`ifdef DATA_SRAM_WBUF_EN
    logic                  wb_valid;
    logic [DEPTH_LOG2-1:0] wb_idx;
    lane_mask_t            wb_mask;
    logic [31:0]           wb_data;
    logic                  wb_hit;
    logic                  wb_merge;
    lane_mask_t            fwd_mask;
    logic [31:0]           fwd_data;

    assign wb_hit   = wb_valid && (wb_idx == req_idx);
    // A store to the buffered word merges in place; anything else drains
    // the entry, including reset so a pending store is never lost.
    assign wb_merge = store && wb_hit && !reset;
    assign wr_mask  = (wb_valid && !wb_merge) ? wb_mask : 4'b0000;
    assign wr_idx   = wb_idx;
    assign wr_data  = wb_data;

    // Buffer entry: capture, merge or drain; stores during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_mask  <= 4'b0000;
        end else if (store) begin
            wb_valid <= 1'b1;
            if (wb_hit) begin
                wb_mask <= wb_mask | data_sram_we;
                wb_data <= merge_bytes(wb_data, data_sram_wdata, data_sram_we);
            end else begin
                wb_idx  <= req_idx;
                wb_mask <= data_sram_we;
                wb_data <= data_sram_wdata;
            end
        end else begin
            wb_valid <= 1'b0;
        end
    end

    // Capture the pre-edge buffer lanes for a read hitting the pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_mask <= 4'b0000;
            fwd_data <= 32'h0;
        end else if (data_sram_en) begin
            fwd_mask <= wb_hit ? wb_mask : 4'b0000;
            fwd_data <= wb_data;
        end
    end

    assign data_sram_rdata = merge_bytes(arr_rdata, fwd_data, fwd_mask);
    assign wbuf_busy       = wb_valid;
`else
    assign wr_mask         = (store && !reset) ? data_sram_we : 4'b0000;
    assign wr_idx          = req_idx;
    assign wr_data         = data_sram_wdata;
    assign data_sram_rdata = arr_rdata;
    assign wbuf_busy       = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp; expectations hold for both the
// buffered and unbuffered builds (wbuf_busy expectation follows the macro).
module tb_data_sram_resp;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        wbuf_busy;

  int vectors;
  int miscompares;

`ifdef DATA_SRAM_WBUF_EN
  localparam logic BUSY_AFTER_STORE = 1'b1;
`else
  localparam logic BUSY_AFTER_STORE = 1'b0;
`endif

  data_sram_resp #(
    .DEPTH_LOG2 (14),
    .INIT_ZERO  (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .wbuf_busy       (wbuf_busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    // store during reset must be discarded
    cyc(1'b1, 4'hF, 32'h400, 32'hDEADBEEF);
    cyc(1'b1, 4'hF, 32'h400, 32'hDEADBEEF);
    reset = 1'b0;

    // reset then idle
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    chk32("reset_rdata", data_sram_rdata, 32'h0);
    chk1("reset_busy", wbuf_busy, 1'b0);
    cyc(1'b1, 4'h0, 32'h400, 32'h0);
    chk32("reset_store_dropped", data_sram_rdata, 32'h0);

    // full write then read
    cyc(1'b1, 4'hF, 32'h100, 32'h11223344);
    chk1("busy_after_store", wbuf_busy, BUSY_AFTER_STORE);
    cyc(1'b1, 4'h0, 32'h100, 32'h0);
    chk32("full_write_read", data_sram_rdata, 32'h11223344);
    chk1("busy_after_read", wbuf_busy, 1'b0);

    // back-to-back partial writes to the same word merge lanes
    cyc(1'b1, 4'b0010, 32'h100, 32'hAAAAAAAA);
    cyc(1'b1, 4'b1000, 32'h100, 32'hBBBBBBBB);
    cyc(1'b1, 4'b0000, 32'h100, 32'h0);
    chk32("lane_merge", data_sram_rdata, 32'hBB22AA44);

    // same-cycle write and read is read-first
    cyc(1'b1, 4'hF, 32'h200, 32'h5);
    chk32("read_first_old", data_sram_rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'h200, 32'h0);
    chk32("read_first_new", data_sram_rdata, 32'h5);

    // en=0 blocks write and holds rdata
    cyc(1'b0, 4'hF, 32'h300, 32'hFFFFFFFF);
    chk32("en0_hold", data_sram_rdata, 32'h5);
    cyc(1'b1, 4'h0, 32'h300, 32'h0);
    chk32("en0_no_write", data_sram_rdata, 32'h0);

    // address wrap modulo depth
    cyc(1'b1, 4'hF, 32'h0001_0000, 32'h0000CAFE);
    cyc(1'b1, 4'h0, 32'h0, 32'h0);
    chk32("wrap_read", data_sram_rdata, 32'h0000CAFE);

    // store pending at reset is committed; store during reset dropped
    cyc(1'b1, 4'hF, 32'h500, 32'h12345678);
    reset = 1'b1;
    cyc(1'b1, 4'hF, 32'h500, 32'h0);
    reset = 1'b0;
    chk32("reset_rdata_again", data_sram_rdata, 32'h0);
    chk1("reset_busy_again", wbuf_busy, 1'b0);
    cyc(1'b1, 4'h0, 32'h500, 32'h0);
    chk32("pending_kept_over_reset", data_sram_rdata, 32'h12345678);

    // store to another word drains the first; both readable
    cyc(1'b1, 4'b0001, 32'h600, 32'h11111111);
    cyc(1'b1, 4'hF, 32'h604, 32'h22222222);
    cyc(1'b1, 4'h0, 32'h600, 32'h0);
    chk32("drain_first", data_sram_rdata, 32'h00000011);
    cyc(1'b1, 4'h0, 32'h604, 32'h0);
    chk32("drain_second", data_sram_rdata, 32'h22222222);

    // byte address low bits ignored
    cyc(1'b1, 4'h0, 32'h607, 32'h0);
    chk32("low_bits_ignored", data_sram_rdata, 32'h22222222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 14, giving the word-address width (2^14 words, 64 KiB).
REQ-002 The module SHALL have parameter INIT_ZERO, default 0; when 1, simulation contents are zero-initialised, otherwise left X.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port data_sram_en, input, 1 bit: access request this cycle.
REQ-006 Port data_sram_we, input, 4 bits: byte-lane write enables; bit i writes wdata[8i+7:8i].
REQ-007 Port data_sram_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 Port data_sram_wdata, input, 32 bits: store data, already lane-replicated by the initiator.
REQ-009 Port data_sram_rdata, output, 32 bits: read data for the previous enabled cycle.
REQ-010 Port wbuf_busy, output, 1 bit: a store is pending in the write buffer; tied 0 when the buffer is compiled out.

Function
REQ-011 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo the depth.
REQ-012 A cycle with en=1 SHALL register data_sram_rdata at the next rising edge (1-cycle latency).
REQ-013 The rdata value SHALL equal the word's contents before any write issued in the same cycle (read-first).
REQ-014 When en=1 and we!=0, only the enabled byte lanes of the addressed word SHALL change; other lanes SHALL be preserved.
REQ-015 When en=0, data_sram_rdata SHALL hold its previous value and no write SHALL occur, whatever we is.
REQ-016 When en=1 and we=4'b0000, the access SHALL be a pure read with no storage change.
REQ-017 Back-to-back writes to the same word SHALL accumulate lane by lane; a read one cycle later SHALL see the merged result.
REQ-018 rdata SHALL be identical cycle-for-cycle with the write buffer compiled in or out.

Reset
REQ-019 On reset, data_sram_rdata SHALL be 32'h0 and wbuf_busy SHALL be 0 from the next edge.
REQ-020 Reset SHALL NOT clear the storage array.
REQ-021 A store issued in the same cycle as reset SHALL be discarded.
REQ-022 A store already pending in the buffer when reset asserts SHALL be committed to the array before the buffer is cleared.

Configuration
REQ-023 With macro DATA_SRAM_WBUF_EN defined, the block SHALL include a one-entry write buffer (valid, index, 4-bit lane mask, 32-bit data).
REQ-024 In buffered mode, a store SHALL enter the buffer and commit to the array at the edge of the next store, or at the first idle cycle, whichever comes first.
REQ-025 In buffered mode, a store to the same index as the pending entry SHALL merge lanes into the entry; the later store's lanes SHALL win.
REQ-026 In buffered mode, a read hitting the pending index SHALL forward buffered lanes over array lanes.
REQ-027 In buffered mode, wbuf_busy SHALL equal the buffer valid bit.
REQ-028 Without DATA_SRAM_WBUF_EN, stores SHALL write the array directly at the request edge and wbuf_busy SHALL be 0.

Structure
REQ-029 Shared package dsram_pkg SHALL hold DEPTH_LOG2 default, the lane-mask type, and a byte-merge function (old, new, mask).
REQ-030 The storage array SHALL be a sub-module dsram_array (1R1W, byte-enable, read-first, synchronous read).

Verification
REQ-031 Scenario: reset, then idle -> rdata==32'h0, wbuf_busy==0.
REQ-032 Scenario: write 32'h11223344 we=4'hF to 0x100, then read 0x100 -> rdata==32'h11223344 one cycle after the read.
REQ-033 Scenario: the word at 0x100 holds 32'h11223344; write wdata=32'hAAAAAAAA we=4'b0010; next cycle write wdata=32'hBBBBBBBB we=4'b1000; then read 0x100 -> rdata==32'hBB22AA44, in both configurations.
REQ-034 Scenario: write and read 0x200 in the same cycle with old value 32'h0, new value 32'h5 -> rdata==32'h0; a read in the next cycle -> 32'h5.
REQ-035 Scenario: en=0 with we=4'hF to 0x300 -> the word at 0x300 is unchanged and rdata holds its previous value.
REQ-036 Scenario: with DEPTH_LOG2=14, write 32'hCAFE to 0x0001_0000, then read 0x0 -> rdata==32'hCAFE (wrap-around).
